bit_serial_core: RTL and testbench

Parametrised bit-serial processor core, next generation of the 8-bit two-register bit-serial machine. The core generalises data width and register count and adds a subtract operation, a program-counter output, and run/halt status. It fetches instructions from an external combinational program memory and executes each arithmetic operation LSB-first through one full adder and one carry flip-flop. It sits between the switch/start front panel and the register display logic.

---
 rtl/bit_serial_core.sv | 162 ++++++++++++++++
 tb/tb_bit_serial_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_core.sv
// Bit-serial core: one full adder + carry FF, LSB-first, DATA_W cycles per op.
// Optional SUB opcode enabled by defining BIT_SERIAL_SUB_EN.
module bit_serial_core #(
  parameter int DATA_W     = 8,
  parameter int REG_N      = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [DATA_W-1:0]             i_data_switch,
  input  logic [2+$clog2(REG_N):0]      i_instr,
  output logic [$clog2(PROG_DEPTH)-1:0] o_pc,
  output logic                          o_busy,
  output logic                          o_halt,
  output logic                          o_instr_done,
  output logic                          o_carry,
  output logic [DATA_W-1:0]             o_acc,
  output logic [REG_N*DATA_W-1:0]       o_regs
);

  localparam int RW = $clog2(REG_N);
  localparam int IW = 3 + RW;
  localparam int PW = $clog2(PROG_DEPTH);
  localparam int CW = $clog2(DATA_W);

`ifdef BIT_SERIAL_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_LDSW, OP_LDA, OP_ADD,
    OP_SUB, OP_STA, OP_CLRA, OP_HALT
  } op_t;

  state_t                        r_state;
  op_t                           r_op;
  logic [RW-1:0]                 r_rd;
  logic [DATA_W-1:0]             r_sw;
  logic [DATA_W-1:0]             r_acc;
  logic [REG_N-1:0][DATA_W-1:0]  r_regs;
  logic [CW-1:0]                 r_cnt;
  logic [PW-1:0]                 r_pc;
  logic                          r_cy;
  logic                          r_carry;
  logic                          r_busy;
  logic                          r_halt;
  logic                          r_done;

  op_t           w_op;
  logic [RW-1:0] w_rd;
  logic          w_rbit;
  logic          w_abit;
  logic          w_b;
  logic          w_sum;
  logic          w_cout;
  logic          w_last;
  logic          w_arith;

  assign w_op    = op_t'(i_instr[IW-1 -: 3]);
  assign w_rd    = i_instr[RW-1:0];
  assign w_rbit  = r_regs[r_rd][0];
  assign w_abit  = r_acc[0];
  // SUB adds the inverted accumulator with carry-in preset to 1
  assign w_b     = (r_op == OP_SUB) ? ~w_abit : w_abit;
  assign w_sum   = w_rbit ^ w_b ^ r_cy;
  assign w_cout  = (w_rbit & w_b) | (r_cy & (w_rbit ^ w_b));
  assign w_last  = (r_cnt == CW'(DATA_W - 1));
  assign w_arith = (r_op == OP_ADD) || ((r_op == OP_SUB) && SUB_EN);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_rd    <= '0;
      r_sw    <= '0;
      r_acc   <= '0;
      r_regs  <= '0;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_cy    <= 1'b0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_halt  <= 1'b0;
          end
        end
        S_FETCH: begin
          r_op  <= w_op;
          r_rd  <= w_rd;
          r_sw  <= i_data_switch;
          r_cy  <= (w_op == OP_SUB);
          r_cnt <= '0;
          if (w_op == OP_HALT) begin
            r_state <= S_HALT;
            r_busy  <= 1'b0;
            r_halt  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt  <= r_cnt + 1'b1;
          r_done <= (r_cnt == CW'(DATA_W - 2));
          unique case (r_op)
            OP_LDSW: begin
              r_regs[r_rd] <= {r_sw[0], r_regs[r_rd][DATA_W-1:1]};
              r_sw         <= {r_sw[0], r_sw[DATA_W-1:1]};
            end
            OP_LDA: begin
              r_acc        <= {w_rbit, r_acc[DATA_W-1:1]};
              r_regs[r_rd] <= {w_rbit, r_regs[r_rd][DATA_W-1:1]};
            end
            OP_ADD, OP_SUB: begin
              if (w_arith) begin
                r_regs[r_rd] <= {w_sum, r_regs[r_rd][DATA_W-1:1]};
                r_acc        <= {w_abit, r_acc[DATA_W-1:1]};
                r_cy         <= w_cout;
              end
            end
            OP_STA: begin
              r_regs[r_rd] <= {w_abit, r_regs[r_rd][DATA_W-1:1]};
              r_acc        <= {w_abit, r_acc[DATA_W-1:1]};
            end
            OP_CLRA: r_acc <= {1'b0, r_acc[DATA_W-1:1]};
            default: ;
          endcase
          if (w_last) begin
            r_pc    <= r_pc + 1'b1;
            r_state <= S_FETCH;
            if (w_arith) r_carry <= w_cout;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pc         = r_pc;
  assign o_busy       = r_busy;
  assign o_halt       = r_halt;
  assign o_instr_done = r_done;
  assign o_carry      = r_carry;
  assign o_acc        = r_acc;
  assign o_regs       = r_regs;

endmodule

// File: tb/tb_bit_serial_core.sv
// Scoreboard bench for bit_serial_core: expected pcs and end-of-program
// state are queued by stimulus and checked by an independent monitor.
module tb_bit_serial_core;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_data_switch;
  logic [4:0]  i_instr;
  logic [3:0]  o_pc;
  logic        o_busy;
  logic        o_halt;
  logic        o_instr_done;
  logic        o_carry;
  logic [7:0]  o_acc;
  logic [31:0] o_regs;

  bit_serial_core #(.DATA_W(8), .REG_N(4), .PROG_DEPTH(16)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_data_switch(i_data_switch),
    .i_instr(i_instr),
    .o_pc(o_pc),
    .o_busy(o_busy),
    .o_halt(o_halt),
    .o_instr_done(o_instr_done),
    .o_carry(o_carry),
    .o_acc(o_acc),
    .o_regs(o_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'b000, LDSW = 3'b001, LDA = 3'b010,
    ADD = 3'b011, SUB = 3'b100, HLT = 3'b111;

  logic [4:0] prog [16];
  logic [7:0] swt  [16];
  logic       use_tab;
  logic [7:0] sw_man;

  assign i_instr       = prog[o_pc];
  assign i_data_switch = use_tab ? swt[o_pc] : sw_man;

  typedef struct {
    logic [31:0] regs;
    logic [7:0]  acc;
    logic        carry;
    logic [3:0]  pc;
    int          ndone;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] pc_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: per-instruction pc on each done pulse, full state on halt
  initial begin
    int   ndone;
    logic halt_d;
    exp_t e;
    ndone  = 0;
    halt_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!i_rst) ndone = 0;
      if (o_instr_done) begin
        ndone++;
        if (pc_q.size() == 0) chk("done_unexpected", o_pc, 4'hx);
        else chk("done_pc", o_pc, pc_q.pop_front());
      end
      if (o_halt && !halt_d) begin
        if (exp_q.size() == 0) begin
          chk("halt_unexpected", o_regs, 32'hx);
        end else begin
          e = exp_q.pop_front();
          chk("halt_regs", o_regs, e.regs);
          chk("halt_acc", o_acc, e.acc);
          chk("halt_carry", o_carry, e.carry);
          chk("halt_pc", o_pc, e.pc);
          chk("halt_ndone", ndone, e.ndone);
        end
        ndone = 0;
      end
      halt_d = o_halt;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst   = 1'b0;
    i_start = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    tick();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      prog[i] = '0;
      swt[i]  = '0;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, o_pc, 0);
    chk({tag, "_regs"}, o_regs, 0);
    chk({tag, "_acc"}, o_acc, 0);
    chk({tag, "_carry"}, o_carry, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_halt"}, o_halt, 0);
    chk({tag, "_done"}, o_instr_done, 0);
  endtask

  // poke 1: start pulse while busy; poke 2: switch change mid-LDSW
  task automatic run_to_halt(input int poke, output int n);
    n = 0;
    while (!o_halt && n < 300) begin
      tick();
      n++;
      if (poke == 1 && n == 5) i_start = 1'b1;
      if (poke == 1 && n == 6) i_start = 1'b0;
      if (poke == 2 && n == 3) sw_man = 8'hFF;
    end
    tick();
  endtask

  task automatic run_sub(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r3, input logic cy,
                         input string tag);
    int n;
    exp_t e;
    do_reset();
    clear_prog();
    prog[0] = {LDSW, 2'd2}; swt[0] = a;
    prog[1] = {LDA,  2'd2};
    prog[2] = {LDSW, 2'd3}; swt[2] = b;
    prog[3] = {SUB,  2'd3};
    prog[4] = {HLT,  2'd0};
    for (int i = 0; i < 4; i++) pc_q.push_back(4'(i));
    e.regs = {r3, a, 16'h0000}; e.acc = a; e.carry = cy;
    e.pc = 4'd4; e.ndone = 4;
    exp_q.push_back(e);
    pulse_start();
    run_to_halt(0, n);
    chk({tag, "_halt_cycle"}, n, 37);
  endtask

  initial begin
    int   n;
    int   nd;
    exp_t e;
    i_rst   = 1'b0;
    i_start = 1'b0;
    use_tab = 1'b1;
    sw_man  = '0;
    clear_prog();

    // reset state, then start
    do_reset();
    chk_zero("rst");
    prog[0] = {LDSW, 2'd0}; swt[0] = 8'hC8;
    prog[1] = {LDA,  2'd0};
    prog[2] = {ADD,  2'd0};
    prog[3] = {HLT,  2'd0};
    for (int i = 0; i < 3; i++) pc_q.push_back(4'(i));
    e.regs = 32'h0000_0090; e.acc = 8'hC8; e.carry = 1'b1;
    e.pc = 4'd3; e.ndone = 3;
    exp_q.push_back(e);
    pulse_start();
    chk("start_busy", o_busy, 1);
    chk("start_pc", o_pc, 0);
    run_to_halt(1, n);
    chk("add_halt_cycle", n, 28);

    // subtract: unequal and equal operands
`ifdef BIT_SERIAL_SUB_EN
    run_sub(8'h05, 8'h03, 8'hFE, 1'b0, "sub_ne");
    run_sub(8'h05, 8'h05, 8'h00, 1'b1, "sub_eq");
`else
    run_sub(8'h05, 8'h03, 8'h03, 1'b0, "sub_ne");
    run_sub(8'h05, 8'h05, 8'h05, 1'b0, "sub_eq");
`endif

    // switch sampled only at fetch
    do_reset();
    clear_prog();
    prog[0] = {LDSW, 2'd1};
    prog[1] = {HLT,  2'd0};
    use_tab = 1'b0;
    sw_man  = 8'h11;
    pc_q.push_back(4'd0);
    e.regs = 32'h0000_1100; e.acc = 8'h00; e.carry = 1'b0;
    e.pc = 4'd1; e.ndone = 1;
    exp_q.push_back(e);
    pulse_start();
    run_to_halt(2, n);
    chk("sw_halt_cycle", n, 10);
    use_tab = 1'b1;

    // pc wrap over a program of 16 NOPs
    do_reset();
    clear_prog();
    for (int i = 0; i < 16; i++) pc_q.push_back(4'(i));
    pc_q.push_back(4'd0);
    pc_q.push_back(4'd1);
    pulse_start();
    nd = 0;
    n  = 0;
    while (nd < 16 && n < 400) begin
      tick();
      n++;
      if (o_instr_done) nd++;
    end
    tick();
    chk("wrap_pc", o_pc, 0);
    chk("wrap_busy", o_busy, 1);
    while (nd < 18 && n < 400) begin
      tick();
      n++;
      if (o_instr_done) nd++;
    end
    chk("wrap_ndone", nd, 18);

    // reset during cycle 4 of ADD exec
    do_reset();
    clear_prog();
    prog[0] = {LDSW, 2'd0}; swt[0] = 8'hC8;
    prog[1] = {LDA,  2'd0};
    prog[2] = {ADD,  2'd0};
    prog[3] = {HLT,  2'd0};
    pc_q.push_back(4'd0);
    pc_q.push_back(4'd1);
    pulse_start();
    repeat (22) tick();
    chk("mid_busy", o_busy, 1);
    chk("mid_pc", o_pc, 2);
    i_rst = 1'b0;
    tick();
    chk_zero("midrst");
    i_rst = 1'b1;
    tick();
    chk("idle_busy", o_busy, 0);
    chk("idle_pc", o_pc, 0);

    tick();
    chk("pc_q_empty", pc_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
